// File: rtl/math_arbiter.sv
// -----------------------------------------------------------------------------
// math_arbiter
//
// Shares one 64x64 multiplier and one shifter between two requesters.
// One operation is in flight at a time; the two request ports are granted
// round-robin and the result comes back on a single tagged response channel
// with a valid/ready handshake.
//
// Parameters:
//   MUL_LAT    cycles from accept to rsp_valid for MUL/SMULH/UMULH (1..8)
//   SHIFT_LAT  cycles from accept to rsp_valid for LSL/LSR/illegal (1..8)
//
// Ports:
//   clk            rising-edge clock
//   reset_n        synchronous active-low reset
//   req_valid[1:0] per-port request valid
//   req_ready[1:0] per-port accept (only in IDLE, only the granted port)
//   req_op0/1      3-bit opcode per port
//   req_a0/1       64-bit operand A per port
//   req_b0/1       64-bit operand B per port (shift distance = B[5:0])
//   rsp_valid      result valid (held until rsp_ready)
//   rsp_ready      consumer accept
//   rsp_id         port that issued the result
//   rsp_data       64-bit result
//   rsp_err        illegal opcode flag
//   busy           high whenever the FSM is not in IDLE
//
// Optional feature (macro MATH_ARB_STATS_EN):
//   grant_cnt0/1   32-bit saturating accept counters per port
// -----------------------------------------------------------------------------
module math_arbiter #(
    parameter int MUL_LAT   = 3,
    parameter int SHIFT_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [2:0]  req_op0,
    input  logic [2:0]  req_op1,
    input  logic [63:0] req_a0,
    input  logic [63:0] req_a1,
    input  logic [63:0] req_b0,
    input  logic [63:0] req_b1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [63:0] rsp_data,
    output logic        rsp_err,
    output logic        busy
`ifdef MATH_ARB_STATS_EN
    ,
    output logic [31:0] grant_cnt0,
    output logic [31:0] grant_cnt1
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    typedef enum logic [2:0] {OP_MUL, OP_SMULH, OP_UMULH, OP_LSL, OP_LSR} op_t;

    localparam logic [2:0] MUL_CNT   = 3'(MUL_LAT - 1);
    localparam logic [2:0] SHIFT_CNT = 3'(SHIFT_LAT - 1);

    state_t      state, next_state;
    logic        ptr;          // round-robin pointer: port that wins a tie
    logic        gnt;          // port granted this cycle (meaningful in IDLE)
    logic        accept;
    logic [2:0]  op_sel;
    logic [2:0]  cnt;

    // Latched request; the math units only ever see these copies.
    logic [2:0]  op_q;
    logic [63:0] a_q, b_q;
    logic        id_q;

    logic [127:0] prod_u;
    logic [63:0]  smulh;
    logic [63:0]  result;
    logic         illegal;

    // ---------------------------------------------------------------------
    // Next-state, grant and handshake logic
    // ---------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        gnt        = ptr;
        accept     = 1'b0;
        req_ready  = 2'b00;
        case (state)
            IDLE: begin
                gnt = req_valid[ptr] ? ptr : ~ptr;
                if (|req_valid) begin
                    accept     = 1'b1;
                    req_ready  = gnt ? 2'b10 : 2'b01;
                    next_state = EXEC;
                end
            end
            EXEC: if (cnt == 3'd0) next_state = DONE;
            DONE: if (rsp_ready)   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign op_sel    = gnt ? req_op1 : req_op0;
    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // ---------------------------------------------------------------------
    // Shared math units, driven from the latched operands
    // ---------------------------------------------------------------------
    // A single unsigned multiplier serves all three multiply ops. The signed
    // high half is derived from the unsigned one: each negative operand
    // contributes an extra -(other operand) * 2^64 to the product.
    always_comb begin
        prod_u  = {64'd0, a_q} * {64'd0, b_q};
        smulh   = prod_u[127:64] - (a_q[63] ? b_q : 64'd0)
                                 - (b_q[63] ? a_q : 64'd0);
        result  = 64'd0;
        illegal = 1'b0;
        case (op_q)
            OP_MUL:   result = prod_u[63:0];
            OP_SMULH: result = smulh;
            OP_UMULH: result = prod_u[127:64];
            OP_LSL:   result = a_q << b_q[5:0];
            OP_LSR:   result = a_q >> b_q[5:0];
            default:  illegal = 1'b1;
        endcase
    end

    // ---------------------------------------------------------------------
    // Control and response registers
    // ---------------------------------------------------------------------
    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            cnt      <= 3'd0;
            rsp_id   <= 1'b0;
            rsp_data <= 64'd0;
            rsp_err  <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                ptr <= ~gnt;
                cnt <= (op_sel <= 3'd2) ? MUL_CNT : SHIFT_CNT;
            end else if (state == EXEC) begin
                if (cnt == 3'd0) begin
                    rsp_id   <= id_q;
                    rsp_data <= result;
                    rsp_err  <= illegal;
                end else begin
                    cnt <= cnt - 3'd1;
                end
            end
        end
    end

    // NOTE: the operand latches carry no reset; they are always written on
    // accept before use, and leaving them unreset keeps reset off a wide
    // datapath enable.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= op_sel;
            a_q  <= gnt ? req_a1 : req_a0;
            b_q  <= gnt ? req_b1 : req_b0;
            id_q <= gnt;
        end
    end

`ifdef MATH_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            grant_cnt0 <= 32'd0;
            grant_cnt1 <= 32'd0;
        end else if (accept) begin
            if (!gnt && grant_cnt0 != 32'hFFFF_FFFF) grant_cnt0 <= grant_cnt0 + 32'd1;
            if (gnt  && grant_cnt1 != 32'hFFFF_FFFF) grant_cnt1 <= grant_cnt1 + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_math_arbiter.sv
// -----------------------------------------------------------------------------
// tb_math_arbiter
//
// Self-checking bench for math_arbiter: directed cases plus a randomized loop,
// all checked against a behavioural model (128-bit arithmetic for results,
// a "last served" pointer for arbitration, expected latency per opcode class).
// Defining MATH_ARB_STATS_EN also checks the grant counters.
// -----------------------------------------------------------------------------
module tb_math_arbiter;

    localparam int MUL_LAT   = 3;
    localparam int SHIFT_LAT = 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [2:0]  req_op0, req_op1;
    logic [63:0] req_a0, req_a1, req_b0, req_b1;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [63:0] rsp_data;
`ifdef MATH_ARB_STATS_EN
    logic [31:0] grant_cnt0, grant_cnt1;
`endif

    math_arbiter #(.MUL_LAT(MUL_LAT), .SHIFT_LAT(SHIFT_LAT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op0   (req_op0),
        .req_op1   (req_op1),
        .req_a0    (req_a0),
        .req_a1    (req_a1),
        .req_b0    (req_b0),
        .req_b1    (req_b1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
`ifdef MATH_ARB_STATS_EN
        ,
        .grant_cnt0(grant_cnt0),
        .grant_cnt1(grant_cnt1)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    int mptr  = 0;
    int mcnt0 = 0;
    int mcnt1 = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    endtask

    // Reference: returns {err, data} straight from the opcode table.
    function automatic logic [64:0] ref_op(input logic [2:0] op, input logic [63:0] a,
                                           input logic [63:0] b);
        logic signed [127:0] sa, sb, sp;
        logic [127:0]        ua, ub, up;
        sa = $signed(a);
        sb = $signed(b);
        sp = sa * sb;
        ua = a;
        ub = b;
        up = ua * ub;
        case (op)
            3'd0:    return {1'b0, up[63:0]};
            3'd1:    return {1'b0, sp[127:64]};
            3'd2:    return {1'b0, up[127:64]};
            3'd3:    return {1'b0, a << b[5:0]};
            3'd4:    return {1'b0, a >> b[5:0]};
            default: return {1'b1, 64'd0};
        endcase
    endfunction

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset_n   = 1'b0;
        req_valid = 2'b00;
        repeat (cycles) @(negedge clk);
        reset_n = 1'b1;
        mptr  = 0;
        mcnt0 = 0;
        mcnt1 = 0;
    endtask

    // One transaction: present requests, check grant, latency, result,
    // optional backpressure hold, and return to IDLE.
    task automatic run_txn(input logic [1:0] vmask, input logic [2:0] op0, input logic [63:0] a0,
                           input logic [63:0] b0, input logic [2:0] op1, input logic [63:0] a1,
                           input logic [63:0] b1, input int stall);
        int          g, lat, cycles;
        logic [2:0]  op;
        logic [63:0] a, b, held_data;
        logic [64:0] exp;
        @(negedge clk);
        req_valid = vmask;
        req_op0 = op0; req_a0 = a0; req_b0 = b0;
        req_op1 = op1; req_a1 = a1; req_b1 = b1;
        rsp_ready = (stall == 0);
        #1;
        g = vmask[mptr] ? mptr : 1 - mptr;
        check("req_ready_grant", {62'd0, req_ready}, (g == 1) ? 64'd2 : 64'd1);
        check("busy_idle", {63'd0, busy}, 64'd0);
        op  = g ? op1 : op0;
        a   = g ? a1 : a0;
        b   = g ? b1 : b0;
        exp = ref_op(op, a, b);
        lat = (op <= 3'd2) ? MUL_LAT : SHIFT_LAT;
        mptr = 1 - g;
        if (g == 0) mcnt0++; else mcnt1++;
        @(posedge clk);
        #1;
        // Scramble the request lines: the latched copies must be used.
        req_valid = 2'b00;
        req_op0 = 3'($urandom); req_a0 = {$urandom, $urandom}; req_b0 = {$urandom, $urandom};
        req_op1 = 3'($urandom); req_a1 = {$urandom, $urandom}; req_b1 = {$urandom, $urandom};
        cycles = 0;
        while (cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
            if (rsp_valid) break;
        end
        check("latency", 64'(cycles), 64'(lat));
        check("rsp_data", rsp_data, exp[63:0]);
        check("rsp_err", {63'd0, rsp_err}, {63'd0, exp[64]});
        check("rsp_id", {63'd0, rsp_id}, 64'(g));
        held_data = rsp_data;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid", {63'd0, rsp_valid}, 64'd1);
            check("stall_data", rsp_data, held_data);
            check("stall_id", {63'd0, rsp_id}, 64'(g));
            check("stall_ready", {62'd0, req_ready}, 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_hs_valid", {63'd0, rsp_valid}, 64'd0);
        check("post_hs_busy", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        reset_n   = 1'b1;
        req_valid = 2'b00;
        req_op0 = 3'd0; req_a0 = 64'd0; req_b0 = 64'd0;
        req_op1 = 3'd0; req_a1 = 64'd0; req_b1 = 64'd0;
        rsp_ready = 1'b1;

        // Reset then idle
        do_reset(2);
        #1;
        check("rst_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_ready", {62'd0, req_ready}, 64'd0);
        check("rst_data", rsp_data, 64'd0);
        check("rst_id_err", {62'd0, rsp_id, rsp_err}, 64'd0);
        run_txn(2'b01, 3'd0, 64'd3, 64'd5, 3'd0, 64'd0, 64'd0, 0);

        // Contention from reset: served 0, 1, 0
        do_reset(2);
        for (int i = 0; i < 3; i++)
            run_txn(2'b11, 3'd3, 64'd1, 64'd4, 3'd4, 64'h80, 64'd3, 0);

        // Signed / unsigned high halves
        run_txn(2'b01, 3'd1, '1, '1, 3'd0, 64'd0, 64'd0, 0);
        run_txn(2'b10, 3'd0, 64'd0, 64'd0, 3'd2, '1, '1, 0);
        run_txn(2'b01, 3'd0, '1, '1, 3'd0, 64'd0, 64'd0, 0);
        run_txn(2'b01, 3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                3'd0, 64'd0, 64'd0, 0);

        // Backpressure for 10 cycles
        run_txn(2'b11, 3'd0, 64'd7, 64'd9, 3'd2, 64'hFFFF_0000_1234_5678, 64'h10, 10);

        // Illegal op and shift boundaries
        run_txn(2'b01, 3'd7, 64'd5, 64'd1, 3'd0, 64'd0, 64'd0, 0);
        run_txn(2'b01, 3'd3, 64'hDEAD_BEEF_DECA_FBAD, 64'd64, 3'd0, 64'd0, 64'd0, 0);
        run_txn(2'b01, 3'd3, 64'hDEAD_BEEF_DECA_FBAD, 64'd63, 3'd0, 64'd0, 64'd0, 0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            logic [1:0] vm;
            vm = 2'($urandom_range(1, 3));
            run_txn(vm, 3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom},
                    3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom},
                    int'($urandom_range(0, 3)));
        end
`ifdef MATH_ARB_STATS_EN
        check("grant_cnt0", {32'd0, grant_cnt0}, 64'(mcnt0));
        check("grant_cnt1", {32'd0, grant_cnt1}, 64'(mcnt1));
`endif

        // Reset mid-EXEC: port 1 MUL, reset one cycle before completion
        @(negedge clk);
        req_valid = 2'b10;
        req_op1 = 3'd0; req_a1 = 64'd11; req_b1 = 64'd13;
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        repeat (MUL_LAT - 2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        mptr = 0;
        #1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
`ifdef MATH_ARB_STATS_EN
        check("midrst_grant_cnt1", {32'd0, grant_cnt1}, 64'd0);
`endif
        begin
            int seen;
            seen = 0;
            repeat (5) begin
                @(negedge clk);
                if (rsp_valid) seen++;
            end
            check("midrst_no_rsp", 64'(seen), 64'd0);
        end
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        check("midrst_ptr0", {62'd0, req_ready}, 64'd1);
        req_valid = 2'b00;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/math_arbiter.md
Name: math_arbiter

Overview:
- Shares one 64-bit multiplier (`mult`) and one shifter (`shifter`) between two requesters, e.g. the execute stage (port 0) and a debug/microcode port (port 1).
- Accepts one operation at a time and arbitrates round-robin between the two ports.
- Models a multi-cycle multiply with a countdown counter.
- Returns one result on a single tagged response channel with valid/ready handshake.

Parameters:
- MUL_LAT, 3, cycles from accept to rsp_valid for multiply ops; legal range 1..8.
- SHIFT_LAT, 1, cycles from accept to rsp_valid for shift and illegal ops; legal range 1..8.

Ports:
- clk  in  1  clock; all logic is on the rising edge
- reset_n  in  1  synchronous active-low reset
- req_valid  in  2  per-port request valid (bit i = port i)
- req_ready  out  2  per-port accept
- req_op0, req_op1  in  3 each  opcode per port
- req_a0, req_a1  in  64 each  operand A per port
- req_b0, req_b1  in  64 each  operand B per port; shift distance = B[5:0]
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accept
- rsp_id  out  1  port that issued the result
- rsp_data  out  64  result
- rsp_err  out  1  illegal opcode flag
- busy  out  1  high in any state other than IDLE

Behaviour:
- Opcodes:
  - 000 MUL: low 64 bits of A*B.
  - 001 SMULH: high 64 bits of the signed product.
  - 010 UMULH: high 64 bits of the unsigned product.
  - 011 LSL: A << B[5:0].
  - 100 LSR: A >> B[5:0], logical.
  - 101-111: illegal; rsp_data = 0, rsp_err = 1.
- States: IDLE, EXEC, DONE.
- Reset (reset_n low at a clock edge):
  - state = IDLE; rsp_valid, rsp_err, rsp_id, busy all 0; rsp_data = 0.
  - Round-robin pointer points to port 0.
  - An in-flight op is discarded with no response.
- IDLE:
  - req_ready[i] = 1 only for the granted port.
  - Grant goes to the pointer port if it is valid, else to the other port if valid.
  - req_ready is 0 for both ports outside IDLE.
  - req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- Accept cycle T (req_valid[i] & req_ready[i]):
  - Latch op, A, B and id = i.
  - Pointer moves to the port not granted.
  - Load the counter with MUL_LAT-1 (ops 000-010) or SHIFT_LAT-1 (all other ops).
  - Go to EXEC.
- EXEC:
  - Counter decrements each cycle.
  - When the counter is 0, register the `mult`/`shifter` output into rsp_data, set rsp_valid and go to DONE.
  - rsp_valid rises exactly at edge T+LAT (first high in cycle T+LAT).
- DONE:
  - rsp_valid, rsp_id, rsp_data and rsp_err are held stable until rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid drops next cycle and state returns to IDLE.
  - The earliest next accept is the cycle after the handshake, so there is no back-to-back overlap.
- Operand changes on req_* after accept have no effect; latched copies drive the math units.
- Both ports valid in IDLE: the pointer port wins and the loser waits. Two back-to-back contending requests are served 0, 1, 0, 1...
- rsp_ready held low indefinitely: the block stalls in DONE and both req_ready stay 0.
- Shift distance uses B[5:0] only; B[63:6] is ignored (distance 64 = 0).
- Signed multiply corner: SMULH of 0x8000000000000000 by itself = 0x4000000000000000.

Optional Feature:
- Macro: MATH_ARB_STATS_EN.
- Defined: adds outputs grant_cnt0 and grant_cnt1 (32-bit each).
  - Each counts accepts on its port.
  - Each saturates at 0xFFFFFFFF.
  - Both reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles -> rsp_valid=0, busy=0, req_ready=2'b00 with no valid; port0 MUL A=3, B=5 -> rsp_valid at T+3, rsp_data=15, rsp_id=0, rsp_err=0.
- Contention: both ports valid from reset, port0 LSL A=1 B=4, port1 LSR A=0x80 B=3, rsp_ready=1 -> port0 served first (0x10), then port1 (0x10, rsp_id=1); both valid again -> port0 granted next.
- Signed/unsigned high: A=-1, B=-1 -> SMULH=0, UMULH=0xFFFFFFFFFFFFFFFE, MUL=1.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_data/rsp_id held constant, req_ready=0 throughout; rsp_ready=1 -> rsp_valid=0 next cycle, IDLE.
- Illegal op 111 with A=5 -> after SHIFT_LAT cycles rsp_err=1, rsp_data=0; shift boundary: LSL A=0xDEADBEEFDECAFBAD B=64 -> result equals A; B=63 -> 0x8000000000000000.
- Reset mid-EXEC: port1 MUL accepted, reset_n=0 one cycle before completion -> no response, pointer=0, busy=0; with MATH_ARB_STATS_EN defined, grant_cnt1=0 after reset.
